sw_debounce: RTL and testbench

- Debounces and conditions raw board switch/key inputs before they reach the switch PIO's `in_port` (default 18 channels).
- Each channel passes through a 2-flop synchronizer and a tick-based stability filter.
- Outputs are clean levels plus one-cycle rise/fall pulses, so the downstream PIO edge capture sees exactly one edge per physical actuation.

---
 rtl/sw_debounce_pkg.sv | 16 +
 rtl/sw_debounce_if.sv | 31 +++
 rtl/sw_debounce_chan.sv | 76 +++++++
 rtl/sw_debounce.sv | 69 ++++++
 tb/tb_sw_debounce.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
//   DEF_*     : default parameter values for the top level
//   cnt_bits  : counter width for a modulo-n counter (never below 1)
package sw_debounce_pkg;

    localparam int unsigned DEF_WIDTH        = 18;
    localparam int unsigned DEF_TICK_DIV     = 50000;
    localparam int unsigned DEF_STABLE_TICKS = 10;
    localparam int unsigned DEF_CNT_W        = 4;

    // Width needed to count 0..n-1; a 1-bit counter is kept when n <= 1.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus between the raw board inputs and the PIO.
//   sw_in      : raw asynchronous switch/key levels
//   enable     : 1 = filter runs, 0 = freeze
//   sw_out     : debounced levels (PIO in_port)
//   rise_pulse : one-cycle pulse per channel on 0->1
//   fall_pulse : one-cycle pulse per channel on 1->0
//   changed    : any rise or fall pulse this cycle
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] sw_in;
    logic             enable;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             changed;

    modport master (
        output sw_in, enable,
        input  sw_out, rise_pulse, fall_pulse, changed
    );

    modport slave (
        input  sw_in, enable,
        output sw_out, rise_pulse, fall_pulse, changed
    );

endinterface

// File: rtl/sw_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, tick-based stability counter,
// debounced level register and registered rise/fall pulses.
//   clk, reset_n : clock, async active-low reset
//   sw_i         : raw asynchronous input
//   tick_i       : shared sample tick (already gated by enable)
//   sw_o         : debounced level
//   rise_o/fall_o: one-cycle pulses coincident with the new sw_o value
//   pulse_c      : next-cycle pulse (rise or fall), for the shared changed flag
module sw_debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter logic        RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_i,
    input  logic tick_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Stability filter: any agreeing cycle clears the count, so only an
    // uninterrupted mismatch lasting STABLE_TICKS ticks is accepted.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (tick_i && ((cnt_q + CNT_W'(1)) == LAST_CNT)) begin
            level_d = s2_q;
            cnt_d   = '0;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end else if (tick_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_o    = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign pulse_c = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH raw switch/key inputs for the switch PIO.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : sw_in/enable in; sw_out, rise_pulse, fall_pulse, changed out
// A shared prescaler produces the sample tick; each channel filters
// independently against that tick.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter int unsigned      TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned      STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned      CNT_W        = DEF_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic        clk,
    input  logic        reset_n,
    sw_debounce_if.slave bus
);

    localparam int unsigned      PCNT_W    = cnt_bits(TICK_DIV);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              tick_c;
    logic [WIDTH-1:0]  pulse_c;
    logic              changed_q;

    // Prescaler: free-runs while enabled, holds its phase while frozen.
    always_comb begin
        pcnt_d = pcnt_q;
        if (bus.enable) begin
            pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
        end
    end

    assign tick_c = bus.enable && (pcnt_q == PCNT_LAST);

    // changed is registered from the channels' next-pulse terms so it lines
    // up with rise_pulse/fall_pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            changed_q <= |pulse_c;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        sw_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W),
            .RESET_VAL    (RESET_VAL[g])
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .sw_i    (bus.sw_in[g]),
            .tick_i  (tick_c),
            .sw_o    (bus.sw_out[g]),
            .rise_o  (bus.rise_pulse[g]),
            .fall_o  (bus.fall_pulse[g]),
            .pulse_c (pulse_c[g])
        );
    end

    assign bus.changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3).
// Stimulus pushes the expected pulse event with its latency window; a
// negedge monitor pops and compares whenever the DUT shows a pulse.
module tb_sw_debounce;

    localparam int unsigned W = 4;

    logic        clk = 1'b0;
    logic        rst0_n;
    logic        rst1_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    sw_debounce_if #(.WIDTH(W)) b0 ();
    sw_debounce_if #(.WIDTH(W)) b1 ();

    sw_debounce #(
        .WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(3), .CNT_W(4), .RESET_VAL(4'h0)
    ) dut0 (
        .clk(clk), .reset_n(rst0_n), .bus(b0)
    );

    sw_debounce #(
        .WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(3), .CNT_W(4), .RESET_VAL(4'hF)
    ) dut1 (
        .clk(clk), .reset_n(rst1_n), .bus(b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  lvl;
        int unsigned t0;
        int unsigned lo;
        int unsigned hi;
    } exp_t;

    exp_t sbq[$];

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [3:0] r, input logic [3:0] f, input logic [3:0] l,
                             input int unsigned lo, input int unsigned hi);
        exp_t e;
        e.rise = r; e.fall = f; e.lvl = l; e.t0 = cyc; e.lo = lo; e.hi = hi;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max && sbq.size() != 0; i++) step(1);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulse event(s) never seen", name, sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   dt;
        if (b0.changed || (|b0.rise_pulse) || (|b0.fall_pulse)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_spurious: rise=%h fall=%h changed=%b expected no pulse (cycle %0d)",
                         b0.rise_pulse, b0.fall_pulse, b0.changed, cyc);
            end else begin
                e = sbq.pop_front();
                chk4("ev_rise", b0.rise_pulse, e.rise);
                chk4("ev_fall", b0.fall_pulse, e.fall);
                chk4("ev_level", b0.sw_out, e.lvl);
                chk4("ev_changed", {3'b000, b0.changed}, 4'h1);
                dt = int'(cyc) - int'(e.t0);
                checks++;
                if (dt < int'(e.lo) || dt > int'(e.hi)) begin
                    errors++;
                    $display("FAIL ev_latency: got %0d cycles expected %0d..%0d", dt, e.lo, e.hi);
                end
            end
        end
        if (rst1_n && (b1.changed || (|b1.rise_pulse) || (|b1.fall_pulse))) begin
            checks++;
            errors++;
            $display("FAIL dut1_spurious: rise=%h fall=%h changed=%b expected no pulse (cycle %0d)",
                     b1.rise_pulse, b1.fall_pulse, b1.changed, cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0_n    = 1'b0;
        rst1_n    = 1'b0;
        b0.sw_in  = 4'h0;
        b0.enable = 1'b1;
        b1.sw_in  = 4'hF;
        b1.enable = 1'b1;
        step(3);
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        // 1: quiet after reset
        chk4("reset_level", b0.sw_out, 4'h0);
        chk4("reset_rise", b0.rise_pulse, 4'h0);
        chk4("reset_fall", b0.fall_pulse, 4'h0);
        chk4("dut1_reset_level", b1.sw_out, 4'hF);
        step(100);
        chk4("idle_level", b0.sw_out, 4'h0);

        // 2: single channel rise
        b0.sw_in[0] = 1'b1;
        expect_ev(4'h1, 4'h0, 4'h1, 11, 14);
        wait_drain("rise_ch0", 30);
        step(30);
        chk4("ch0_high", b0.sw_out, 4'h1);

        // 3: bouncing channel 1 never reaches three stable ticks
        for (int k = 0; k < 8; k++) begin
            b0.sw_in[1] = ~b0.sw_in[1];
            step(5);
        end
        step(30);
        chk4("bounce_rejected", b0.sw_out, 4'h1);

        // back to all-zero for the freeze test
        b0.sw_in[0] = 1'b0;
        expect_ev(4'h0, 4'h1, 4'h0, 11, 14);
        wait_drain("fall_ch0", 30);

        // 4: frozen filter, then release all four together
        b0.enable = 1'b0;
        b0.sw_in  = 4'hF;
        step(50);
        chk4("frozen_level", b0.sw_out, 4'h0);
        b0.enable = 1'b1;
        expect_ev(4'hF, 4'h0, 4'hF, 9, 12);
        wait_drain("unfreeze_all", 30);
        chk4("all_high", b0.sw_out, 4'hF);

        // 5: single fall, then async reset in the middle of a count
        b0.sw_in[2] = 1'b0;
        expect_ev(4'h0, 4'h4, 4'hB, 11, 14);
        wait_drain("fall_ch2", 30);
        b0.sw_in[3] = 1'b0;
        step(7);
        @(negedge clk);
        #1;
        rst0_n   = 1'b0;
        b0.sw_in = 4'h0;
        #1;
        chk4("async_reset_level", b0.sw_out, 4'h0);
        chk4("async_reset_rise", b0.rise_pulse, 4'h0);
        chk4("async_reset_fall", b0.fall_pulse, 4'h0);
        chk4("async_reset_changed", {3'b000, b0.changed}, 4'h0);
        step(2);
        rst0_n = 1'b1;
        step(60);
        chk4("post_reset_level", b0.sw_out, 4'h0);

        // 6: all-ones reset value with keys released
        chk4("dut1_final_level", b1.sw_out, 4'hF);
        chk4("scoreboard_empty", 4'(sbq.size()), 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
